// File: rtl/pipeline_step_ctrl_if.sv
// rtl/pipeline_step_ctrl_if.sv - debug command and pipeline control bundle for pipeline_step_ctrl
interface pipeline_step_ctrl_if #(
   parameter int CNT_BITS = 32
);
   logic                cmd_valid;
   logic [1:0]          cmd;
   logic                cmd_ready;
   logic                halt_wb;
   logic                load_use;
   logic                step;
   logic                pc_write;
   logic                ifid_write;
   logic                flush_idex;
   logic                flush_all;
   logic                halted;
   logic                busy;
   logic [CNT_BITS-1:0] cycle_count;

   modport master (
      output cmd_valid, cmd, halt_wb, load_use,
      input  cmd_ready, step, pc_write, ifid_write, flush_idex, flush_all,
             halted, busy, cycle_count
   );

   modport slave (
      input  cmd_valid, cmd, halt_wb, load_use,
      output cmd_ready, step, pc_write, ifid_write, flush_idex, flush_all,
             halted, busy, cycle_count
   );
endinterface

// File: rtl/pipeline_step_ctrl.sv
// rtl/pipeline_step_ctrl.sv - run/step/halt/flush controller producing pipeline latch enables
module pipeline_step_ctrl #(
   parameter int CNT_BITS     = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   pipeline_step_ctrl_if.slave   bus
);
   localparam logic [1:0] CMD_RUN   = 2'b01;
   localparam logic [1:0] CMD_STEP  = 2'b10;
   localparam logic [1:0] CMD_FLUSH = 2'b11;
   localparam int         FW        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_STEP, S_HALTED, S_FLUSH} state_t;

   state_t              state, state_next;
   logic [FW-1:0]       flush_cnt;
   logic [CNT_BITS-1:0] cnt;
   logic                step_r, flush_all_r, halted_r, busy_r, cmd_ready_r;
   logic                accept;

   assign accept = bus.cmd_valid & cmd_ready_r;

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (accept) begin
               case (bus.cmd)
                  CMD_RUN:   state_next = S_RUN;
                  CMD_STEP:  state_next = S_STEP;
                  CMD_FLUSH: state_next = S_FLUSH;
                  default:   state_next = S_IDLE;
               endcase
            end
         end
         S_RUN:    if (bus.halt_wb) state_next = S_HALTED;
         S_STEP:   state_next = bus.halt_wb ? S_HALTED : S_IDLE;
         S_HALTED: if (accept && bus.cmd == CMD_FLUSH) state_next = S_FLUSH;
         S_FLUSH:  if (flush_cnt == FLUSH_LAST) state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // Outputs are flopped from the next state so step/flush_all never see i_cmd or halt_wb combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         flush_cnt   <= '0;
         cnt         <= '0;
         step_r      <= 1'b0;
         flush_all_r <= 1'b0;
         halted_r    <= 1'b0;
         busy_r      <= 1'b0;
         cmd_ready_r <= 1'b1;
      end else begin
         state       <= state_next;
         step_r      <= (state_next == S_RUN) || (state_next == S_STEP);
         flush_all_r <= (state_next == S_FLUSH);
         halted_r    <= (state_next == S_HALTED);
         busy_r      <= (state_next == S_RUN) || (state_next == S_FLUSH);
         cmd_ready_r <= (state_next == S_IDLE) || (state_next == S_HALTED);

         if (state == S_FLUSH)
            flush_cnt <= flush_cnt + FW'(1);
         else
            flush_cnt <= '0;

         if (state_next == S_FLUSH && state != S_FLUSH)
            cnt <= '0;
         else if (step_r && cnt != '1)
            cnt <= cnt + CNT_BITS'(1);
      end
   end

   assign bus.step        = step_r;
   assign bus.flush_all   = flush_all_r;
   assign bus.halted      = halted_r;
   assign bus.busy        = busy_r;
   assign bus.cmd_ready   = cmd_ready_r;
   assign bus.cycle_count = cnt;
   assign bus.pc_write    = step_r & ~bus.load_use;
   assign bus.ifid_write  = step_r & ~bus.load_use;
   assign bus.flush_idex  = flush_all_r | (step_r & bus.load_use);
endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// tb/tb_pipeline_step_ctrl.sv - scoreboard bench for pipeline_step_ctrl
module tb_pipeline_step_ctrl;
   logic clk;
   logic rst_n;

   pipeline_step_ctrl_if #(.CNT_BITS(32)) bus ();
   pipeline_step_ctrl_if #(.CNT_BITS(4))  bus4 ();

   pipeline_step_ctrl #(.CNT_BITS(32), .FLUSH_CYCLES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   pipeline_step_ctrl #(.CNT_BITS(4), .FLUSH_CYCLES(2)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus4.slave)
   );

   assign bus4.cmd_valid = bus.cmd_valid;
   assign bus4.cmd       = bus.cmd;
   assign bus4.halt_wb   = bus.halt_wb;
   assign bus4.load_use  = bus.load_use;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Expected per active cycle: {step, flush_all, pc_write, ifid_write, flush_idex}
   logic [4:0] sb[$];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_step(input logic lu);
      sb.push_back({1'b1, 1'b0, ~lu, ~lu, lu});
   endtask

   task automatic push_flush();
      sb.push_back(5'b01001);
   endtask

   task automatic send_cmd(input logic [1:0] c);
      bus.cmd_valid = 1'b1;
      bus.cmd       = c;
      tick();
      bus.cmd_valid = 1'b0;
      bus.cmd       = 2'b00;
   endtask

   always @(negedge clk) begin
      if (rst_n && (bus.step || bus.flush_all)) begin
         if (sb.size() == 0)
            check_eq("unexpected_activity", {27'd0, bus.step, bus.flush_all, bus.pc_write,
                     bus.ifid_write, bus.flush_idex}, 32'd0);
         else
            check_eq("sb_ctrl", {27'd0, bus.step, bus.flush_all, bus.pc_write,
                     bus.ifid_write, bus.flush_idex}, {27'd0, sb.pop_front()});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd       = 2'b00;
      bus.halt_wb   = 1'b0;
      bus.load_use  = 1'b0;
      tick();
      tick();
      check_eq("rst_step", bus.step, 1'b0);
      check_eq("rst_flush_idex", bus.flush_idex, 1'b0);
      check_eq("rst_cmd_ready", bus.cmd_ready, 1'b1);
      check_eq("rst_halted", bus.halted, 1'b0);
      check_eq("rst_busy", bus.busy, 1'b0);
      check_eq("rst_count", bus.cycle_count, 32'd0);
      rst_n = 1'b1;
      tick();

      // RUN for 10 steps, halt sampled on the 10th
      for (int i = 0; i < 10; i++) push_step(1'b0);
      send_cmd(2'b01);
      check_eq("run_busy", bus.busy, 1'b1);
      check_eq("run_cmd_ready", bus.cmd_ready, 1'b0);
      for (int i = 0; i < 10; i++) begin
         bus.halt_wb = (i == 9);
         tick();
      end
      bus.halt_wb = 1'b0;
      check_eq("run10_count", bus.cycle_count, 32'd10);
      check_eq("run10_halted", bus.halted, 1'b1);
      check_eq("run10_cmd_ready", bus.cmd_ready, 1'b1);
      check_eq("run10_step", bus.step, 1'b0);

      // STEP while halted is ignored
      send_cmd(2'b10);
      tick();
      check_eq("halt_step_ignored", bus.step, 1'b0);
      check_eq("halt_still", bus.halted, 1'b1);

      // FLUSH from HALTED
      push_flush();
      push_flush();
      send_cmd(2'b11);
      check_eq("flush_count_clr", bus.cycle_count, 32'd0);
      check_eq("flush_busy", bus.busy, 1'b1);
      check_eq("flush_halted", bus.halted, 1'b0);
      tick();
      check_eq("flush_2nd", bus.flush_all, 1'b1);
      tick();
      check_eq("flush_done", bus.flush_all, 1'b0);
      check_eq("flush_cmd_ready", bus.cmd_ready, 1'b1);
      check_eq("flush_busy_off", bus.busy, 1'b0);

      // Three spaced STEP commands
      for (int k = 0; k < 3; k++) begin
         push_step(1'b0);
         send_cmd(2'b10);
         check_eq("step_pulse", bus.step, 1'b1);
         tick();
         check_eq("step_single", bus.step, 1'b0);
         tick();
      end
      check_eq("step3_count", bus.cycle_count, 32'd3);
      check_eq("step3_idle_ready", bus.cmd_ready, 1'b1);
      check_eq("step3_halted", bus.halted, 1'b0);

      // STEP during load-use: bubble, PC and IF/ID held, counter still advances
      push_step(1'b1);
      bus.load_use = 1'b1;
      send_cmd(2'b10);
      tick();
      bus.load_use = 1'b0;
      check_eq("step_lu_count", bus.cycle_count, 32'd4);

      // STEP held valid: accepted every other cycle
      for (int i = 0; i < 3; i++) push_step(1'b0);
      bus.cmd_valid = 1'b1;
      bus.cmd       = 2'b10;
      for (int i = 0; i < 6; i++) tick();
      bus.cmd_valid = 1'b0;
      bus.cmd       = 2'b00;
      tick();
      check_eq("step_held_count", bus.cycle_count, 32'd7);

      // RUN with a load-use mid-run, then halt and load-use on the same edge
      push_step(1'b0); push_step(1'b0); push_step(1'b1); push_step(1'b0); push_step(1'b1);
      send_cmd(2'b01);
      for (int i = 0; i < 5; i++) begin
         bus.load_use = (i == 2) || (i == 4);
         bus.halt_wb  = (i == 4);
         tick();
      end
      bus.load_use = 1'b0;
      bus.halt_wb  = 1'b0;
      check_eq("run_lu_count", bus.cycle_count, 32'd12);
      check_eq("run_lu_halted", bus.halted, 1'b1);

      // Async reset mid-RUN
      push_flush();
      push_flush();
      send_cmd(2'b11);
      tick();
      tick();
      for (int i = 0; i < 3; i++) push_step(1'b0);
      send_cmd(2'b01);
      for (int i = 0; i < 3; i++) tick();
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_step", bus.step, 1'b0);
      check_eq("arst_count", bus.cycle_count, 32'd0);
      check_eq("arst_busy", bus.busy, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();
      check_eq("arst_ready", bus.cmd_ready, 1'b1);
      check_eq("arst_idle_step", bus.step, 1'b0);
      check_eq("arst_halted", bus.halted, 1'b0);

      // 20-step RUN: 4-bit counter saturates
      for (int i = 0; i < 20; i++) push_step(1'b0);
      send_cmd(2'b01);
      for (int i = 0; i < 20; i++) begin
         bus.halt_wb = (i == 19);
         tick();
      end
      bus.halt_wb = 1'b0;
      tick();
      check_eq("sat_count32", bus.cycle_count, 32'd20);
      check_eq("sat_count4", {28'd0, bus4.cycle_count}, 32'd15);
      check_eq("sat_halted4", bus4.halted, 1'b1);

      check_eq("sb_drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
